// File: rtl/fp64_pkg.sv
// Shared binary64 field layout, special constants and the adder's FSM encoding.
package fp64_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 11;
  localparam int MAN_W  = 52;
  localparam int BIAS   = 1023;

  // Working significand: hidden bit + 52 mantissa bits + guard/round/sticky
  localparam int SIG_W  = 1 + MAN_W + 3;

  localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;
  localparam logic [63:0]      QNAN    = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    ROUND  = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == EXP_MAX) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == EXP_MAX) && (x[51:0] == 52'd0);
  endfunction

  // Exponent field zero covers both true zero and subnormals (flushed to zero)
  function automatic logic is_zero(input logic [63:0] x);
    return (x[62:52] == 11'd0);
  endfunction

endpackage

// File: rtl/fp64_adder_lzc64.sv
// Combinational 64-bit leading-zero counter; all-zero input yields 64.
module lzc64 (
  input  logic [63:0] value,
  output logic [6:0]  count
);

  logic found;

  // Scan from the MSB and latch the position of the first set bit
  always_comb begin
    count = 7'd64;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 7'(63 - i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fp64_adder.sv
// Iterative binary64 adder: one operation in flight, one pipeline step per
// cycle (UNPACK, ALIGN, ADD, NORM, ROUND), result held in DONE until taken.
module fp64_adder
  import fp64_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] c
);

  state_t state_r, state_s;

  logic [63:0]       a_r, b_r, spec_val_r, c_r;
  logic              spec_r, sign_r, sub_r, zero_r, out_valid_r;
  logic [10:0]       diff_r;
  logic signed [12:0] exp_r;
  logic [SIG_W-1:0]  big_r, small_r, norm_r;
  logic [SIG_W:0]    sum_r;

  logic              spec_s, a_ge_s;
  logic [63:0]       spec_val_s;
  logic [111:0]      ext_s;
  logic [SIG_W-1:0]  align_s, norm_s;
  logic signed [12:0] nexp_s, fexp_s;
  logic [6:0]        lz_s;
  logic              rnd_up_s;
  logic [53:0]       rnd_s;
  logic [51:0]       mant_s;
  logic [63:0]       res_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign c         = c_r;

  lzc64 u_lzc (
    .value ({sum_r[SIG_W-1:0], 8'h00}),
    .count (lz_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state: fixed walk through the datapath steps, wait in IDLE/DONE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_s = UNPACK; else state_s = IDLE;
      UNPACK:  state_s = ALIGN;
      ALIGN:   state_s = ADD;
      ADD:     state_s = NORM;
      NORM:    state_s = ROUND;
      ROUND:   state_s = DONE;
      DONE:    if (out_valid_r && out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Special-operand decode and magnitude ordering of the registered operands
  always_comb begin
    spec_s     = 1'b1;
    spec_val_s = 64'd0;
    a_ge_s     = (a_r[62:0] >= b_r[62:0]);
    if (is_nan(a_r) || is_nan(b_r)) begin
      spec_val_s = QNAN;
    end else if (is_inf(a_r) && is_inf(b_r)) begin
      if (a_r[63] != b_r[63]) spec_val_s = QNAN;
      else                    spec_val_s = a_r;
    end else if (is_inf(a_r)) begin
      spec_val_s = a_r;
    end else if (is_inf(b_r)) begin
      spec_val_s = b_r;
    end else if (is_zero(a_r) && is_zero(b_r)) begin
      spec_val_s = {a_r[63] & b_r[63], 63'd0};
    end else if (is_zero(a_r)) begin
      spec_val_s = b_r;
    end else if (is_zero(b_r)) begin
      spec_val_s = a_r;
    end else begin
      spec_s = 1'b0;
    end
  end

  // Right-shift the smaller significand; everything shifted out folds into sticky
  always_comb begin
    ext_s   = {small_r, 56'd0} >> diff_r;
    align_s = {ext_s[111:57], ext_s[56] | (|ext_s[55:0])};
  end

  // Normalise: 1-bit right shift on carry-out, otherwise left shift by lz count
  always_comb begin
    if (sum_r[SIG_W]) begin
      norm_s = {sum_r[SIG_W:2], sum_r[1] | sum_r[0]};
      nexp_s = exp_r + 13'sd1;
    end else begin
      norm_s = sum_r[SIG_W-1:0] << lz_s;
      nexp_s = exp_r - $signed({6'd0, lz_s});
    end
  end

  // Round to nearest even and pack, with overflow/underflow/special override
  always_comb begin
    rnd_up_s = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
    rnd_s    = {1'b0, norm_r[SIG_W-1:3]} + {53'd0, rnd_up_s};
    if (rnd_s[53]) begin
      fexp_s = exp_r + 13'sd1;
      mant_s = rnd_s[52:1];
    end else begin
      fexp_s = exp_r;
      mant_s = rnd_s[51:0];
    end
    if (spec_r) begin
      res_s = spec_val_r;
    end else if (zero_r) begin
      res_s = 64'd0;
    end else if (int'(fexp_s) - BIAS > BIAS) begin
      res_s = {sign_r, EXP_MAX, 52'd0};
    end else if (int'(fexp_s) - BIAS < 1 - BIAS) begin
      res_s = {sign_r, 63'd0};
    end else begin
      res_s = {sign_r, fexp_s[10:0], mant_s};
    end
  end

  // Datapath registers, each updated only in the step that owns it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= 64'd0;
      b_r         <= 64'd0;
      spec_val_r  <= 64'd0;
      c_r         <= 64'd0;
      spec_r      <= 1'b0;
      sign_r      <= 1'b0;
      sub_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
      diff_r      <= 11'd0;
      exp_r       <= 13'sd0;
      big_r       <= '0;
      small_r     <= '0;
      norm_r      <= '0;
      sum_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        UNPACK: begin
          spec_r     <= spec_s;
          spec_val_r <= spec_val_s;
          sub_r      <= a_r[63] ^ b_r[63];
          if (a_ge_s) begin
            sign_r  <= a_r[63];
            exp_r   <= $signed({2'b00, a_r[62:52]});
            big_r   <= {1'b1, a_r[51:0], 3'b000};
            small_r <= {1'b1, b_r[51:0], 3'b000};
            diff_r  <= a_r[62:52] - b_r[62:52];
          end else begin
            sign_r  <= b_r[63];
            exp_r   <= $signed({2'b00, b_r[62:52]});
            big_r   <= {1'b1, b_r[51:0], 3'b000};
            small_r <= {1'b1, a_r[51:0], 3'b000};
            diff_r  <= b_r[62:52] - a_r[62:52];
          end
        end
        ALIGN: small_r <= align_s;
        ADD: begin
          if (sub_r) sum_r <= {1'b0, big_r} - {1'b0, small_r};
          else       sum_r <= {1'b0, big_r} + {1'b0, small_r};
        end
        NORM: begin
          norm_r <= norm_s;
          exp_r  <= nexp_s;
          zero_r <= (sum_r == '0);
        end
        ROUND: c_r <= res_s;
        DONE: begin
          if (out_valid_r && out_ready) out_valid_r <= 1'b0;
          else                          out_valid_r <= 1'b1;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule
